// File: rtl/switch_irq_ctrl.sv
// APB3 interrupt controller for four debounced switch event sources:
// pending/mask registers, saturating event counters, and an IRQ FSM with ack holdoff.
module switch_irq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic [3:0]  EVT,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic        en_reg, en_next;
  logic [15:0] holdoff_reg, holdoff_next;
  logic [3:0]  mask_reg, mask_next;
  logic [3:0]  pend_reg, pend_next;
  logic [1:0]  id_reg;
  logic        valid_reg;
  logic [15:0] hcnt_reg;
  logic [1:0]  winner;
  logic [3:0]  active_reg, active_next;
  logic [31:0] cnt_word;
  logic [31:0] rdata;
  logic [2:0]  reg_idx;
  logic [6:0]  wr_sel;
  logic        wr, ack_fire, irq;
  logic        unused_bits;

  assign reg_idx     = PADDR[4:2];
  assign wr          = PSEL & PENABLE & PWRITE;
  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[15:4]};

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr & (reg_idx == 3'(gi));
    end
  endgenerate

  assign ack_fire = wr_sel[4] & (state_reg == ASSERT);

  // Register next values; an event always beats a same-cycle clear.
  always_comb begin
    en_next      = wr_sel[0] ? PWDATA[0] : en_reg;
    holdoff_next = wr_sel[0] ? PWDATA[31:16] : holdoff_reg;
    mask_next    = wr_sel[1] ? PWDATA[3:0] : mask_reg;
    pend_next    = pend_reg;
    if (wr_sel[2])
      pend_next = pend_next & ~PWDATA[3:0];
    if (ack_fire)
      pend_next[id_reg] = 1'b0;
    pend_next = pend_next | EVT;
  end

  assign active_reg  = pend_reg & mask_reg;
  assign active_next = pend_next & mask_next;

  always_comb begin
    if (active_reg[0])      winner = 2'd0;
    else if (active_reg[1]) winner = 2'd1;
    else if (active_reg[2]) winner = 2'd2;
    else                    winner = 2'd3;
  end

  // FSM: state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM: next state. Entry looks at registered sources, exit at the post-write view.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en_reg && (active_reg != 4'd0)) state_next = ASSERT;
      ASSERT: begin
        if (ack_fire)                                state_next = HOLD;
        else if (!en_next || (active_next == 4'd0)) state_next = IDLE;
      end
      HOLD:    if (hcnt_reg == 16'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    irq = (state_reg == ASSERT);
  end

  assign IRQ = irq;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_reg      <= 1'b0;
      holdoff_reg <= 16'd0;
      mask_reg    <= 4'd0;
      pend_reg    <= 4'd0;
      id_reg      <= 2'd0;
      valid_reg   <= 1'b0;
      hcnt_reg    <= 16'd0;
    end else begin
      en_reg      <= en_next;
      holdoff_reg <= holdoff_next;
      mask_reg    <= mask_next;
      pend_reg    <= pend_next;
      if (state_reg == IDLE && state_next == ASSERT) begin
        id_reg    <= winner;
        valid_reg <= 1'b1;
      end else if (state_reg == ASSERT && state_next != ASSERT) begin
        valid_reg <= 1'b0;
      end
      if (ack_fire)
        hcnt_reg <= holdoff_reg;
      else if (state_reg == HOLD && hcnt_reg != 16'd0)
        hcnt_reg <= hcnt_reg - 16'd1;
    end
  end

  // Per-source saturating counters, each zero-extended into its own byte lane.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
          cnt_reg <= '0;
        else if (wr_sel[5])
          cnt_reg <= EVT[gi] ? CNT_W'(1) : '0;
        else if (EVT[gi] && (cnt_reg != {CNT_W{1'b1}}))
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
      assign cnt_word[gi*8 +: 8] = 8'(cnt_reg);
    end
  endgenerate

  always_comb begin
    rdata = 32'd0;
    if (PSEL) begin
      case (reg_idx)
        3'd0:    rdata = {holdoff_reg, 15'd0, en_reg};
        3'd1:    rdata = {28'd0, mask_reg};
        3'd2:    rdata = {28'd0, pend_reg};
        3'd3:    rdata = {valid_reg, 29'd0, id_reg};
        3'd5:    rdata = cnt_word;
        3'd6:    rdata = {30'd0, state_reg};
        default: rdata = 32'd0;
      endcase
    end
  end

  assign PRDATA  = rdata;
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & (reg_idx == 3'd7);

endmodule

// File: tb/tb_switch_irq_ctrl.sv
// Self-checking bench for switch_irq_ctrl: directed scenarios plus random APB/EVT
// traffic, all compared against a transaction-level reference model.
module tb_switch_irq_ctrl;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] A_CTRL = 32'h00, A_MASK = 32'h04, A_PEND = 32'h08, A_ID = 32'h0C;
  localparam logic [31:0] A_ACK = 32'h10, A_CNT = 32'h14, A_STAT = 32'h18, A_BAD = 32'h1C;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [3:0]  EVT;
  logic        IRQ;

  switch_irq_ctrl #(.CNT_W(CNT_W)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .EVT(EVT), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: mode 0 idle, 1 interrupt raised, 2 ack holdoff.
  int m_en, m_holdoff, m_mask, m_pend, m_mode, m_hcnt, m_id, m_valid;
  int m_cnt[4];

  logic [31:0] last_rdata;
  logic        last_err;
  bit          rnd_on = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_en = 0; m_holdoff = 0; m_mask = 0; m_pend = 0;
    m_mode = 0; m_hcnt = 0; m_id = 0; m_valid = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endfunction

  function automatic logic [31:0] model_read(int idx);
    case (idx)
      0: return {16'(m_holdoff), 15'd0, 1'(m_en)};
      1: return 32'(m_mask);
      2: return 32'(m_pend);
      3: return {1'(m_valid), 29'd0, 2'(m_id)};
      5: return {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
      6: return 32'(m_mode);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lowest(int v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  function automatic void model_step(bit sel, bit en, bit wr, logic [31:0] addr,
                                     logic [31:0] data, logic [3:0] evt);
    bit w      = sel && en && wr;
    int idx    = int'(addr[4:2]);
    bit ack    = w && idx == 4 && m_mode == 1;
    int active = m_pend & m_mask;
    int n_pend = m_pend;
    int n_en   = m_en;
    int n_mask = m_mask;
    if (w && idx == 2) n_pend = n_pend & ~int'(data[3:0]);
    if (ack) n_pend = n_pend & ~(1 << m_id);
    n_pend = n_pend | int'(evt);
    if (w && idx == 0) begin
      n_en = int'(data[0]);
      m_holdoff_upd: begin end
    end
    if (w && idx == 1) n_mask = int'(data[3:0]);
    for (int i = 0; i < 4; i++) begin
      if (w && idx == 5) m_cnt[i] = 0;
      if (evt[i]) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
    end
    case (m_mode)
      0: if (m_en != 0 && active != 0) begin
           m_mode = 1; m_id = lowest(active); m_valid = 1;
         end
      1: if (ack) begin
           m_mode = 2; m_valid = 0; m_hcnt = m_holdoff;
         end else if (n_en == 0 || (n_pend & n_mask) == 0) begin
           m_mode = 0; m_valid = 0;
         end
      default: if (m_hcnt == 0) m_mode = 0; else m_hcnt--;
    endcase
    if (w && idx == 0) m_holdoff = int'(data[31:16]);
    m_pend = n_pend; m_en = n_en; m_mask = n_mask;
  endfunction

  function automatic logic [3:0] rnd_evt();
    if (rnd_on && $urandom_range(0, 5) == 0) return 4'($urandom_range(0, 15));
    return 4'd0;
  endfunction

  task automatic tick(bit sel, bit en, bit wr, logic [31:0] addr, logic [31:0] data,
                      logic [3:0] evt);
    @(negedge PCLK);
    PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PWDATA = data; EVT = evt;
    #1;
    last_rdata = PRDATA;
    last_err   = PSLVERR;
    check("prdata", PRDATA, sel ? model_read(int'(addr[4:2])) : 32'd0);
    check("pslverr", 32'(PSLVERR), 32'(sel && en && addr[4:2] == 3'd7));
    check("pready", 32'(PREADY), 32'd1);
    model_step(sel, en, wr, addr, data, evt);
    @(posedge PCLK);
    #1;
    check("irq", 32'(IRQ), 32'(m_mode == 1));
  endtask

  task automatic idle(logic [3:0] evt);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, evt);
  endtask

  task automatic apb_write(logic [31:0] addr, logic [31:0] data, logic [3:0] evt);
    tick(1'b1, 1'b0, 1'b1, addr, data, rnd_evt());
    tick(1'b1, 1'b1, 1'b1, addr, data, evt | rnd_evt());
    $display("apb write addr=0x%02h data=0x%08h evt=%b irq=%0d", addr[7:0], data, evt, IRQ);
  endtask

  task automatic apb_read(logic [31:0] addr, output logic [31:0] data);
    tick(1'b1, 1'b0, 1'b0, addr, 32'd0, rnd_evt());
    tick(1'b1, 1'b1, 1'b0, addr, 32'd0, rnd_evt());
    data = last_rdata;
    $display("apb read  addr=0x%02h data=0x%08h irq=%0d", addr[7:0], data, IRQ);
  endtask

  task automatic count_low(output int n);
    n = 0;
    for (int k = 0; k < 40 && IRQ == 1'b0; k++) begin
      n++;
      idle(4'd0);
    end
  endtask

  task automatic wait_irq(string tag);
    for (int k = 0; k < 40 && IRQ == 1'b0; k++) idle(4'd0);
    check(tag, 32'(IRQ), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    #2;
    PRESET = 1'b1; EVT = 4'hF; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    #1;
    model_reset();
    check("irq_async_reset", 32'(IRQ), 32'd0);
    repeat (2) @(posedge PCLK);
    #2;
    PRESET = 1'b0; EVT = 4'd0;
    $display("reset pulse done");
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'd0; PWDATA = 32'd0; EVT = 4'd0;
    model_reset();
    repeat (2) @(posedge PCLK);
    #2;
    check("reset_irq", 32'(IRQ), 32'd0);
    PRESET = 1'b0;
    for (int a = 0; a < 8; a++) begin
      apb_read(32'(a * 4), rd);
      check("reset_reg", rd, 32'd0);
    end

    // Single source raises IRQ one edge after becoming pending.
    apb_write(A_MASK, 32'hF, 4'd0);
    apb_write(A_CTRL, 32'h1, 4'd0);
    idle(4'b0100);
    apb_read(A_PEND, rd);
    check("basic_pend", rd, 32'h4);
    check("basic_irq", 32'(IRQ), 32'd1);
    apb_read(A_ID, rd);
    check("basic_id", rd, 32'h80000002);
    apb_read(A_CNT, rd);
    check("basic_cnt", rd, 32'h00010000);

    // Priority between simultaneous sources; holdoff 0 gives one HOLD cycle.
    apb_write(A_ACK, 32'd0, 4'd0);
    idle(4'b1010);
    wait_irq("prio_irq");
    apb_read(A_ID, rd);
    check("prio_id", rd, 32'h80000001);
    apb_write(A_ACK, 32'd0, 4'd0);
    count_low(n);
    check("holdoff0_low", 32'(n), 32'd2);
    apb_read(A_PEND, rd);
    check("prio_pend", rd, 32'h8);
    apb_read(A_ID, rd);
    check("prio_id3", rd, 32'h80000003);

    // Latched ID is sticky; holdoff 3 keeps IRQ low for five cycles.
    apb_write(A_CTRL, 32'h00030001, 4'd0);
    idle(4'b0001);
    apb_read(A_ID, rd);
    check("id_sticky", rd, 32'h80000003);
    apb_write(A_ACK, 32'd0, 4'd0);
    count_low(n);
    check("holdoff3_low", 32'(n), 32'd5);
    apb_read(A_ID, rd);
    check("reassert_id", rd, 32'h80000000);

    // W1C races with an event, then clears the only source.
    apb_write(A_PEND, 32'h1, 4'b0001);
    apb_read(A_PEND, rd);
    check("w1c_race_pend", rd, 32'h1);
    apb_write(A_PEND, 32'h1, 4'd0);
    check("w1c_drop_irq", 32'(IRQ), 32'd0);
    apb_read(A_STAT, rd);
    check("w1c_stat", rd, 32'd0);

    // Counter saturation and clear racing with an event.
    for (int k = 0; k < 265; k++) idle(4'b0001);
    apb_read(A_CNT, rd);
    check("cnt_sat", rd & 32'hFF, 32'hFF);
    apb_write(A_CNT, 32'd0, 4'b0001);
    apb_read(A_CNT, rd);
    check("cnt_clear_race", rd, 32'h00000001);

    // Bad address, then asynchronous reset while IRQ is high.
    check("pre_bad_irq", 32'(IRQ), 32'd1);
    apb_write(A_BAD, 32'hFFFFFFFF, 4'd0);
    check("bad_slverr", 32'(last_err), 32'd1);
    check("bad_rdata", last_rdata, 32'd0);
    apb_read(A_CTRL, rd);
    check("bad_no_change", rd, 32'h00030001);
    do_reset();
    idle(4'b0010);
    apb_read(A_PEND, rd);
    check("post_reset_evt", rd, 32'h2);
    apb_read(A_CNT, rd);
    check("post_reset_cnt", rd, 32'h00000100);

    // Random traffic against the model.
    rnd_on = 1'b1;
    for (int k = 0; k < 500; k++) begin
      case ($urandom_range(0, 9))
        0, 1: idle(rnd_evt());
        2: apb_write(A_CTRL, {16'($urandom_range(0, 3)), 15'd0, 1'($urandom_range(0, 4) != 0)}, 4'd0);
        3: apb_write(A_MASK, $urandom, 4'd0);
        4: apb_write(A_PEND, $urandom, 4'd0);
        5, 9: apb_write(A_ACK, $urandom, 4'd0);
        6: apb_write(A_CNT, $urandom, 4'd0);
        7: apb_read(32'($urandom_range(0, 7) * 4), rd);
        default: apb_write(A_BAD, $urandom, 4'd0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
